hdbn_sub_encoder: RTL and testbench
===================================

Name: hdbn_sub_encoder

Overview:
- Parametrised HDBn line-code substitution encoder for a single channel.
- Accepts a valid-qualified binary bitstream and outputs 2-bit symbol codes (00 zero, 01 mark, 10 B, 11 V) plus a ternary polarity bit for the line driver.
- Performs both V and B insertion in one block and runs any order n (HDB3 when N=3).
- Supports a runtime AMI bypass mode and a saturating substitution counter for link statistics.

Parameters:
- N, 3, max consecutive zeros allowed; a run of N+1 zeros is substituted; legal range 1..15
- CNT_W, 16, width of the substitution counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_vld  in  1  input beat strobe; pipeline advances only on beats
- in_bit  in  1  data bit for the beat
- mode_ami  in  1  1 = plain AMI with no substitution; sampled per beat
- out_vld  out  1  registered copy of in_vld
- out_sym  out  2  symbol leaving the pipeline: 00 zero, 01 mark, 10 B, 11 V
- out_pol  out  1  pulse polarity: 0 = positive or zero, 1 = negative
- sub_cnt  out  CNT_W  count of substitutions, saturating at all-ones

Behaviour:
- Reset (async, rst=1):
  - Pipeline slots s[0..N] = 00; zrun = 0; parity = 0; last_pol = 1.
  - out_vld = 0, out_sym = 00, out_pol = 0, sub_cnt = 0.
  - Reset mid-stream discards all buffered symbols.
- Pipeline: N+1 slots; s[0] is newest, s[N] is oldest. On a beat:
  - s[N] is registered to out_sym.
  - All slots shift toward s[N].
  - The new symbol enters s[0].
- Latency:
  - A bit accepted on beat k appears on the out_vld beat k+N+1; the output is registered, one clk after the beat.
  - The first N+1 output beats after reset are flush zeros (00).
  - Between beats, out_vld = 0 and out_sym/out_pol hold their values.
- Zero-run counter zrun:
  - Counts consecutive real input zeros; flush zeros never count.
  - in_bit=1 clears zrun.
- Substitution trigger: beat with in_bit=0, zrun==N and mode_ami=0. On that beat:
  - s[0] <= 11 (V).
  - If parity==0, the slot receiving the shifted former s[N-1] is written 10 (B), so the run becomes B0..0V. If parity==1, the run is 0..0V.
  - zrun <= 0; parity <= 0; sub_cnt increments, holding at 2^CNT_W-1.
- Non-trigger beat:
  - s[0] <= {0, in_bit}.
  - in_bit=1 toggles parity.
  - zrun updates as above.
- AMI mode: in mode_ami=1 a zero beat with zrun==N does not substitute, and zrun still wraps to 0. Mode may change on any beat with no flush, and symbols already in the pipeline are unchanged.
- Polarity (output side, evaluated as a symbol leaves s[N]):
  - 00: out_pol=0.
  - 01/10: out_pol = ~last_pol, then last_pol <= out_pol.
  - 11: out_pol = last_pol, so V repeats the previous mark; last_pol is unchanged.
  - The first mark after reset is positive.
- Simultaneous cases: in_vld and substitution on the same beat use pre-update zrun/parity. A substituted V never counts as a zero, so back-to-back runs substitute independently.

Test Plan:
- Reset, then 4 beats in_bit=0 (N=3):
  - First 4 out beats are flush 00/pol 0.
  - Next out beats are 10,00,00,11 with pol 0,0,0,0 (B+, V+); sub_cnt=1.
- After reset, feed 1,0,0,0,0 plus 4 flush-zero beats:
  - Data out is 01,00,00,00,11 (parity odd, 000V), pol 0,0,0,0,0 (V repeats +).
- After reset, feed 1,1,0,0,0,0:
  - Out is 01,10... only if parity even: parity=0 after two marks, so the run gives 10,00,00,11.
  - Full stream 01,01,10,00,00,11 with pol 0,1,0,0,0,0.
- 8 zeros after reset:
  - Output 10,00,00,11,10,00,00,11, pol 0,0,0,0,1,0,0,1; sub_cnt=2.
- mode_ami=1, 8 zeros then 1,1,1:
  - Eight 00 symbols, then 01,01,01 with pol 0,1,0; sub_cnt=0.
- Robustness and counter limits:
  - Insert random in_vld gaps in the 8-zero case: identical symbol sequence; out_vld pulses exactly one cycle after each beat.
  - Assert rst mid-run: outputs return to reset values immediately.
  - With CNT_W=2, 5 substitutions: sub_cnt holds at 3.

Source files
------------

// File: rtl/hdbn_sub_encoder.sv
// HDBn substitution encoder: turns a beat-qualified bitstream into B/V/mark/zero
// symbols with line polarity, holding N+1 symbols so a B can be planted retroactively.
module hdbn_sub_encoder #(
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_bit,
  input  logic             mode_ami,
  output logic             out_vld,
  output logic [1:0]       out_sym,
  output logic             out_pol,
  output logic [CNT_W-1:0] sub_cnt
);

  localparam int ZW = $clog2(N + 1);

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_MARK = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  localparam logic [ZW-1:0]    ZRUN_MAX = ZW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]    slot [0:N];
  logic [ZW-1:0] zrun;
  logic          parity;
  logic          last_pol;

  logic          zrun_full;
  logic          sub_fire;
  logic [1:0]    new_sym;
  logic [ZW-1:0] zrun_nxt;
  logic          leave_pol;
  logic          last_pol_nxt;

  // A run of N+1 real zeros fires a substitution unless AMI bypass is selected.
  always_comb begin
    zrun_full = (zrun == ZRUN_MAX);
    sub_fire  = in_vld & ~in_bit & ~mode_ami & zrun_full;
    new_sym   = sub_fire ? SYM_V : {1'b0, in_bit};
    zrun_nxt  = (in_bit | zrun_full) ? '0 : zrun + ZW'(1);
  end

  always_comb begin
    leave_pol    = 1'b0;
    last_pol_nxt = last_pol;
    case (slot[N])
      SYM_MARK, SYM_B: begin
        leave_pol    = ~last_pol;
        last_pol_nxt = ~last_pol;
      end
      SYM_V: begin
        leave_pol    = last_pol;
      end
      default: begin
        leave_pol    = 1'b0;
      end
    endcase
  end

  // Delay line; on an even-parity substitution the oldest run zero becomes B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= N; i++) begin
        slot[i] <= SYM_ZERO;
      end
    end else if (in_vld) begin
      for (int i = N; i > 0; i--) begin
        slot[i] <= slot[i-1];
      end
      slot[0] <= new_sym;
      if (sub_fire && !parity) begin
        slot[N] <= SYM_B;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zrun     <= '0;
      parity   <= 1'b0;
      last_pol <= 1'b1;
      out_vld  <= 1'b0;
      out_sym  <= SYM_ZERO;
      out_pol  <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_sym  <= slot[N];
        out_pol  <= leave_pol;
        last_pol <= last_pol_nxt;
        zrun     <= zrun_nxt;
        if (sub_fire) begin
          parity <= 1'b0;
        end else if (in_bit) begin
          parity <= ~parity;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_cnt <= '0;
    end else if (sub_fire && (sub_cnt != CNT_MAX)) begin
      sub_cnt <= sub_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hdbn_sub_encoder.sv
// Scoreboard bench for hdbn_sub_encoder: a symbol-history model feeds an expected
// queue that a negedge monitor drains against two instances (wide and 2-bit counter).
module tb_hdbn_sub_encoder;

  localparam int N     = 3;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_vld = 1'b0;
  logic             in_bit = 1'b0;
  logic             mode_ami = 1'b0;
  logic             out_vld;
  logic [1:0]       out_sym;
  logic             out_pol;
  logic [CNT_W-1:0] sub_cnt;
  logic             sat_out_vld;
  logic [1:0]       sat_out_sym;
  logic             sat_out_pol;
  logic [SAT_W-1:0] sat_sub_cnt;

  typedef struct {
    int sym;
    int pol;
  } exp_t;

  exp_t exp_q[$];
  int   got_sym[$];
  int   got_pol[$];
  int   hist[$];
  int   m_zrun;
  int   m_par;
  int   m_last_pol;
  int   m_subs;
  int   m_out_idx;
  int   errors = 0;
  int   checks = 0;
  int   prev_sym = 0;
  int   prev_pol = 0;
  logic vld_pipe;

  hdbn_sub_encoder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_bit(in_bit), .mode_ami(mode_ami),
    .out_vld(out_vld), .out_sym(out_sym), .out_pol(out_pol), .sub_cnt(sub_cnt)
  );

  hdbn_sub_encoder #(.N(N), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_bit(in_bit), .mode_ami(mode_ami),
    .out_vld(sat_out_vld), .out_sym(sat_out_sym), .out_pol(sat_out_pol), .sub_cnt(sat_sub_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= 1'b0;
    else     vld_pipe <= in_vld;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: full symbol history (flush zeros first); a substitution rewrites the
  // first zero of the current run to B when the mark count since the last one is even.
  task automatic modelReset();
    hist.delete();
    for (int i = 0; i <= N; i++) hist.push_back(0);
    m_zrun = 0; m_par = 0; m_last_pol = 1; m_subs = 0; m_out_idx = 0;
  endtask

  task automatic modelBeat(input int b, input int ami);
    exp_t e;
    if (b == 0 && ami == 0 && m_zrun == N) begin
      if (m_par == 0) hist[hist.size() - N] = 2;
      hist.push_back(3);
      m_zrun = 0; m_par = 0; m_subs++;
    end else begin
      hist.push_back(b);
      if (b != 0) begin
        m_zrun = 0; m_par = 1 - m_par;
      end else begin
        m_zrun = (m_zrun == N) ? 0 : m_zrun + 1;
      end
    end
    e.sym = hist[m_out_idx];
    m_out_idx++;
    if (e.sym == 0) e.pol = 0;
    else if (e.sym == 3) e.pol = m_last_pol;
    else begin
      e.pol = 1 - m_last_pol;
      m_last_pol = e.pol;
    end
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit vld, input bit b, input bit ami);
    @(posedge clk);
    #1;
    in_vld = vld; in_bit = b; mode_ami = ami;
    if (vld) modelBeat(int'(b), int'(ami));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'($urandom_range(0, 1)), mode_ami);
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_out_vld", int'(out_vld), 0);
    checkOutput("rst_out_sym", int'(out_sym), 0);
    checkOutput("rst_out_pol", int'(out_pol), 0);
    checkOutput("rst_sub_cnt", int'(sub_cnt), 0);
    checkOutput("rst_sat_sub_cnt", int'(sat_sub_cnt), 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every output beat pops one expected symbol; idle cycles must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete(); got_sym.delete(); got_pol.delete();
      prev_sym = 0; prev_pol = 0;
    end else begin
      checkOutput("out_vld", int'(out_vld), int'(vld_pipe));
      checkOutput("sat_out_vld", int'(sat_out_vld), int'(vld_pipe));
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("[TB] FAIL scoreboard_empty: got out_vld=1 expected no output at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_sym", int'(out_sym), e.sym);
          checkOutput("out_pol", int'(out_pol), e.pol);
          checkOutput("sat_out_sym", int'(sat_out_sym), e.sym);
          checkOutput("sat_out_pol", int'(sat_out_pol), e.pol);
        end
        got_sym.push_back(int'(out_sym));
        got_pol.push_back(int'(out_pol));
      end else begin
        checkOutput("hold_out_sym", int'(out_sym), prev_sym);
        checkOutput("hold_out_pol", int'(out_pol), prev_pol);
      end
      prev_sym = int'(out_sym);
      prev_pol = int'(out_pol);
    end
  end

  // Directed run: symv packs 2 bits per expected data symbol, polv 1 bit per pulse.
  task automatic runDirected(input string name, input int len, input logic [15:0] bits,
                             input bit ami, input bit gaps, input logic [31:0] symv,
                             input logic [15:0] polv, input int exp_sub);
    doReset();
    for (int i = 0; i < len; i++) begin
      if (gaps) idle(int'($urandom_range(0, 3)));
      applyStimulus(1'b1, bits[i], ami);
    end
    for (int i = 0; i <= N; i++) applyStimulus(1'b1, 1'b1, ami);
    idle(3);
    checkOutput({name, "_beats"}, got_sym.size(), len + N + 1);
    if (got_sym.size() >= len + N + 1) begin
      for (int i = 0; i <= N; i++) begin
        checkOutput({name, "_flush_sym"}, got_sym[i], 0);
        checkOutput({name, "_flush_pol"}, got_pol[i], 0);
      end
      for (int i = 0; i < len; i++) begin
        checkOutput({name, "_sym"}, got_sym[N + 1 + i], int'(symv[2*i +: 2]));
        checkOutput({name, "_pol"}, got_pol[N + 1 + i], int'(polv[i]));
      end
    end
    checkOutput({name, "_sub_cnt"}, int'(sub_cnt), exp_sub);
  endtask

  initial begin
    bit ami;
    int exp_sat;
    modelReset();

    runDirected("four_zeros",       4,  16'h0000, 1'b0, 1'b0, 32'h0000_00C2, 16'h0000, 1);
    runDirected("mark_then_run",    5,  16'h0001, 1'b0, 1'b0, 32'h0000_0301, 16'h0000, 1);
    runDirected("two_marks_run",    6,  16'h0003, 1'b0, 1'b0, 32'h0000_0C25, 16'h0002, 1);
    runDirected("eight_zeros",      8,  16'h0000, 1'b0, 1'b0, 32'h0000_C2C2, 16'h0090, 2);
    runDirected("ami_mode",         11, 16'h0700, 1'b1, 1'b0, 32'h0015_0000, 16'h0200, 0);
    runDirected("eight_zeros_gaps", 8,  16'h0000, 1'b0, 1'b1, 32'h0000_C2C2, 16'h0090, 2);

    // Counter saturation: five substitutions against the 2-bit counter.
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= N; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    idle(3);
    checkOutput("sat_wide_sub_cnt", int'(sub_cnt), 5);
    checkOutput("sat_narrow_sub_cnt", int'(sat_sub_cnt), 3);

    // Random zero-heavy traffic with gaps, mode flips and a reset mid-stream.
    doReset();
    ami = 1'b0;
    for (int it = 0; it < 600; it++) begin
      if (it == 300) doReset();
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        if ($urandom_range(0, 15) == 0) ami = !ami;
        applyStimulus(1'b1, $urandom_range(0, 3) == 0, ami);
      end
    end
    for (int i = 0; i <= N; i++) applyStimulus(1'b1, 1'b1, ami);
    idle(3);
    exp_sat = (m_subs > 3) ? 3 : m_subs;
    checkOutput("rand_sub_cnt", int'(sub_cnt), m_subs);
    checkOutput("rand_sat_sub_cnt", int'(sat_sub_cnt), exp_sat);
    checkOutput("rand_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
